counter_checker: RTL

Passive checker that sits on the output side of the 4-bit up-counter's interface (`enable`, synchronous clear, `data`). It samples the same control inputs the counter sees plus the counter's `data` output, predicts the next count every cycle, and reports lock status, single-cycle mismatch pulses, a saturating error count and a wrap count. It is instantiated beside the counter in benches and in self-checking top levels; it never drives the counter.

---
 rtl/counter_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/counter_checker.sv
// counter_checker
// Passive checker for a WIDTH-bit up-counter with enable and synchronous clear.
// Every cycle it predicts the counter value from the previous sample. It then
// reports lock status, a one-cycle mismatch pulse, a saturating error count and
// a count of verified max-to-0 wraps. It never drives the counter.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   enable      counter enable as seen by the counter
//   clear       counter synchronous clear (active high, priority over enable)
//   data        counter output under check
//   locked      high while the checker is locked to the count stream
//   err         one-cycle pulse on a mismatch while locked
//   err_count   mismatches while locked, saturating at all-ones
//   wrap_count  verified max-to-0 wraps, rolls over
//   expected    combinational prediction for the current sample
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | first edge after reset: load previous-sample registers only
// TRACK  | counting consecutive correct predictions toward LOCK_THRESH
// LOCKED | locked; mismatches pulse err and fall back to TRACK
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int WRAP_W      = 8,
    parameter int LOCK_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [WIDTH-1:0]  data,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  expected
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [4:0]       THRESH  = 5'(LOCK_THRESH);

    state_t              state, state_nx;
    logic [WIDTH-1:0]    p_data;
    logic                p_en, p_clr;
    logic [3:0]          good, good_nx;
    logic                err_nx;
    logic [ERR_W-1:0]    err_count_nx;
    logic [WRAP_W-1:0]   wrap_count_nx;
    logic                match;
    logic                wrap_hit;

    always_comb begin
        if (p_clr) begin
            expected = '0;
        end else if (p_en) begin
            expected = p_data + WIDTH'(1);
        end else begin
            expected = p_data;
        end
    end

    assign match = (data == expected);

    // A clear-to-0 never qualifies: only an enabled increment out of max counts.
    assign wrap_hit = p_en && !p_clr && (p_data == CNT_MAX) && (data == '0);

    always_comb begin
        state_nx      = state;
        good_nx       = good;
        err_nx        = 1'b0;
        err_count_nx  = err_count;
        wrap_count_nx = wrap_count;
        case (state)
            IDLE: begin
                state_nx = TRACK;
                good_nx  = '0;
            end
            TRACK: begin
                if (match) begin
                    good_nx = good + 4'd1;
                    if (({1'b0, good} + 5'd1) == THRESH) begin
                        state_nx = LOCKED;
                    end
                end else begin
                    good_nx = '0;
                end
            end
            LOCKED: begin
                if (match) begin
                    if (wrap_hit) begin
                        wrap_count_nx = wrap_count + WRAP_W'(1);
                    end
                end else begin
                    err_nx   = 1'b1;
                    state_nx = TRACK;
                    good_nx  = '0;
                    if (err_count != '1) begin
                        err_count_nx = err_count + ERR_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                good_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            good       <= '0;
            p_data     <= '0;
            p_en       <= 1'b0;
            p_clr      <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nx;
            good       <= good_nx;
            p_data     <= data;
            p_en       <= enable;
            p_clr      <= clear;
            err        <= err_nx;
            err_count  <= err_count_nx;
            wrap_count <= wrap_count_nx;
        end
    end

    assign locked = (state == LOCKED);

endmodule
